// File: rtl/rgb_pwm_driver_if.sv
// rgb_pwm_driver_if -- bundles the brightness selects coming from the
// mode-select stage together with the PWM, duty and status outputs of
// rgb_pwm_driver. The master side supplies the selects and observes the
// outputs; the slave side is the driver itself.
interface rgb_pwm_driver_if #(
   parameter int PWM_BITS = 8
);
   // per-channel level selects, 0..4 valid, 5..7 treated as 4
   logic [2:0]          sel_r;
   logic [2:0]          sel_g;
   logic [2:0]          sel_b;
   // active-high PWM outputs to the LED pins
   logic                led_r;
   logic                led_g;
   logic                led_b;
   // current duty per channel, observation only
   logic [PWM_BITS-1:0] duty_r;
   logic [PWM_BITS-1:0] duty_g;
   logic [PWM_BITS-1:0] duty_b;
   // one-clk pulse at each PWM period boundary
   logic                period_start;
   // high while any duty has not yet reached its target
   logic                busy;

   modport master (
      output sel_r, sel_g, sel_b,
      input  led_r, led_g, led_b,
      input  duty_r, duty_g, duty_b,
      input  period_start, busy
   );

   modport slave (
      input  sel_r, sel_g, sel_b,
      output led_r, led_g, led_b,
      output duty_r, duty_g, duty_b,
      output period_start, busy
   );
endinterface

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver -- maps three 3-bit brightness selects to target duties,
// ramps each active duty toward its target by at most RAMP_STEP once per
// PWM period, and drives three glitch-free registered PWM outputs.
// Duty, target sampling and busy all change only on the period boundary
// (the clk edge on which pwm_cnt wraps to 0).
//
// Build option: define RGB_PWM_GAMMA_EN to replace the linear level map
// with a perceptual gamma table (0/8/32/96/255 scaled to PWM_BITS).
// The interface instance must be built with the same PWM_BITS.
module rgb_pwm_driver #(
   parameter int PRE_DIV   = 50,  // clk cycles per PWM tick, >= 1
   parameter int PWM_BITS  = 8,   // PWM counter width, 3..12
   parameter int RAMP_STEP = 8    // max duty change per period, >= 1
) (
   input logic             clk,
   input logic             rst_n,
   rgb_pwm_driver_if.slave bus
);

   localparam int NUM_CH = 3;
   localparam int MAX_I  = (1 << PWM_BITS) - 1;
   localparam int Q_I    = 1 << (PWM_BITS - 2);
   localparam int PRE_W  = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

   localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(MAX_I);

   // A step wider than full scale behaves exactly like a full-scale step.
   localparam int              STEP_I = (RAMP_STEP > MAX_I) ? MAX_I : RAMP_STEP;
   localparam logic [PWM_BITS:0] STEP = (PWM_BITS + 1)'(STEP_I);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

`ifdef RGB_PWM_GAMMA_EN
   // Gamma table is defined for 8 bits; rescale to the counter width.
   localparam int G_SHL = (PWM_BITS >= 8) ? (PWM_BITS - 8) : 0;
   localparam int G_SHR = (PWM_BITS < 8)  ? (8 - PWM_BITS) : 0;
   localparam logic [PWM_BITS-1:0] LVL1 = PWM_BITS'((8  << G_SHL) >> G_SHR);
   localparam logic [PWM_BITS-1:0] LVL2 = PWM_BITS'((32 << G_SHL) >> G_SHR);
   localparam logic [PWM_BITS-1:0] LVL3 = PWM_BITS'((96 << G_SHL) >> G_SHR);
`else
   localparam logic [PWM_BITS-1:0] LVL1 = PWM_BITS'(Q_I);
   localparam logic [PWM_BITS-1:0] LVL2 = PWM_BITS'(2 * Q_I);
   localparam logic [PWM_BITS-1:0] LVL3 = PWM_BITS'(3 * Q_I);
`endif

   // Select-to-duty map; every select at or above 4 is full scale.
   function automatic logic [PWM_BITS-1:0] level(input logic [2:0] sel);
      case (sel)
         3'd0:    return '0;
         3'd1:    return LVL1;
         3'd2:    return LVL2;
         3'd3:    return LVL3;
         default: return MAX;
      endcase
   endfunction

   // One ramp step toward the target, computed one bit wider so the
   // intermediate sum/difference can neither wrap nor overshoot.
   function automatic logic [PWM_BITS-1:0] ramp(input logic [PWM_BITS-1:0] duty,
                                                input logic [PWM_BITS-1:0] tgt);
      logic [PWM_BITS:0] d;
      logic [PWM_BITS:0] t;
      logic [PWM_BITS:0] r;
      d = {1'b0, duty};
      t = {1'b0, tgt};
      if (d < t)
         r = ((t - d) > STEP) ? (d + STEP) : t;
      else if (d > t)
         r = ((d - t) > STEP) ? (d - STEP) : t;
      else
         r = d;
      return r[PWM_BITS-1:0];
   endfunction

   logic [PRE_W-1:0]    pre_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                period_start_q;
   logic                busy_q;
   logic [PWM_BITS-1:0] duty_q     [NUM_CH];
   logic                led_q      [NUM_CH];

   logic [2:0]          sel_v      [NUM_CH];
   logic [PWM_BITS-1:0] target_nxt [NUM_CH];
   logic [PWM_BITS-1:0] duty_nxt   [NUM_CH];
   logic                led_nxt    [NUM_CH];
   logic                busy_nxt;
   logic                tick;
   logic                boundary;

   assign sel_v[0] = bus.sel_r;
   assign sel_v[1] = bus.sel_g;
   assign sel_v[2] = bus.sel_b;

   assign tick     = (pre_cnt == PRE_LAST);
   assign boundary = tick && (pwm_cnt == MAX);

   // Per-channel target, next duty, busy flag and PWM compare.
   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      busy_nxt = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         target_nxt[c] = level(sel_v[c]);
         duty_nxt[c]   = ramp(duty_q[c], target_nxt[c]);
         busy_nxt      = busy_nxt | (duty_nxt[c] != target_nxt[c]);
         // Extremes are forced so duty 0 and MAX never produce a 1-tick sliver.
         if (duty_q[c] == MAX)
            led_nxt[c] = 1'b1;
         else if (duty_q[c] == '0)
            led_nxt[c] = 1'b0;
         else
            led_nxt[c] = (pwm_cnt < duty_q[c]);
      end
   end

   // Prescaler, PWM counter and the registered period-boundary pulse.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt        <= '0;
         pwm_cnt        <= '0;
         period_start_q <= 1'b0;
      end else begin
         period_start_q <= boundary;
         if (tick) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
         end
      end
   end

   // Duty ramp and busy update, applied only on the period boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) duty_q[c] <= '0;
      end else if (boundary) begin
         busy_q <= busy_nxt;
         for (int c = 0; c < NUM_CH; c++) duty_q[c] <= duty_nxt[c];
      end
   end

   // Registered PWM outputs, one clk behind the counter and duty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) led_q[c] <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) led_q[c] <= led_nxt[c];
      end
   end

   assign bus.duty_r       = duty_q[0];
   assign bus.duty_g       = duty_q[1];
   assign bus.duty_b       = duty_q[2];
   assign bus.led_r        = led_q[0];
   assign bus.led_g        = led_q[1];
   assign bus.led_b        = led_q[2];
   assign bus.period_start = period_start_q;
   assign bus.busy         = busy_q;

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Downstream consumer of the per-channel 3-bit brightness selects (sel_r/g/b, range 0..4) produced by the mode-select stage. It maps each select to a target duty, ramps the active duty toward the target once per PWM period, and drives three glitch-free PWM outputs to the RGB LED pins. All duty changes happen only at PWM period boundaries.

Parameters:
PRE_DIV, 50, clk cycles per PWM tick; legal range >=1.
PWM_BITS, 8, PWM counter width; one period = 2^PWM_BITS ticks; legal range 3..12.
RAMP_STEP, 8, maximum duty change per channel per PWM period; legal range >=1, and RAMP_STEP = 2^PWM_BITS-1 gives an instant jump.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
sel_r  in  3  red level select; 0..4 valid, 5..7 treated as 4
sel_g  in  3  green level select; same rules as sel_r
sel_b  in  3  blue level select; same rules as sel_r
led_r  out  1  red PWM output; active high
led_g  out  1  green PWM output
led_b  out  1  blue PWM output
duty_r  out  PWM_BITS  current red duty; observation only
duty_g  out  PWM_BITS  current green duty
duty_b  out  PWM_BITS  current blue duty
period_start  out  1  one-clk pulse at each PWM period boundary
busy  out  1  high while any channel's duty differs from its target

Behaviour:
- Reset (asynchronous, active-low) clears pre_cnt, pwm_cnt, all duty_*, led_*, period_start and busy to 0. Outputs stay 0 after release until logic drives them.
- Prescaler: pre_cnt counts 0..PRE_DIV-1 and wraps. The tick is the cycle where pre_cnt==PRE_DIV-1.
- PWM counter: on tick, pwm_cnt increments and wraps from 2^PWM_BITS-1 to 0. No tick means hold.
- Boundary: the edge on which pwm_cnt wraps to 0. period_start is registered high for exactly that one clk cycle.
- Level map (MAX = 2^PWM_BITS-1, Q = 2^(PWM_BITS-2)):
  - sel 0 -> 0
  - sel 1 -> Q
  - sel 2 -> 2Q
  - sel 3 -> 3Q
  - sel >=4 -> MAX
- Target sampling: targets are computed from sel_* sampled on the boundary edge only. sel changes mid-period are ignored until the next boundary; several sel changes within one period mean only the final value counts.
- Ramp, per channel, on the boundary edge:
  - if duty < target: duty <= min(duty+RAMP_STEP, target)
  - if duty > target: duty <= max(duty-RAMP_STEP, target)
  - otherwise hold
  - Arithmetic uses one extra bit; never overshoot, never wrap.
- A target reversal mid-ramp takes effect at the next boundary, moving from the current duty.
- PWM output (registered, 1 clk after pwm_cnt updates):
  - led = 1 when duty==MAX
  - led = 0 when duty==0
  - otherwise led = (pwm_cnt < duty)
  - duty 0 gives no pulses and duty MAX gives a constant high: no 1-tick slivers at either extreme.
- busy: registered; high when any channel's duty != its latched target. Updated on the boundary edge.
- Reset mid-ramp: everything returns to 0, and the ramp restarts from 0 at the first boundary after release.

Optional Feature:
- Macro: RGB_PWM_GAMMA_EN.
- Defined: the level map is replaced by a perceptual gamma table, scaled to PWM_BITS by a left shift of (PWM_BITS-8) when PWM_BITS>=8, or a right shift of (8-PWM_BITS) when PWM_BITS<8. sel 4 (and 5..7) always map to MAX.
  - sel 0 -> 0
  - sel 1 -> 8
  - sel 2 -> 32
  - sel 3 -> 96
  - sel 4 -> 255
- Not defined: the linear map above. Ramp, timing and all ports are identical either way.

Test Plan:
- Reset check (PRE_DIV=2, PWM_BITS=8, RAMP_STEP=8): hold rst_n low 10 clk -> all led_*/duty_*/busy/period_start = 0; period_start then pulses every 512 clk.
- Linear ramp up: sel_r=2 before a boundary -> duty_r 8,16,...,128 over 16 periods; busy drops on the boundary where duty_r hits 128; led_r high for 128 of 256 ticks (256 clk per 512-clk period).
- Extremes: sel_g=4 with RAMP_STEP=255 -> duty_g=255 after one boundary, led_g constantly high; then sel_g=0 -> duty_g=0 next boundary, led_g never pulses.
- Mid-period sel change: sel_b 0->3->1 within one period -> next boundary targets 64; duty_b=8, and 3Q=192 is never targeted.
- Reversal and saturation: duty_r ramping up at 40, sel_r=0 -> duty_r 32,24,...,0 without underflow; sel_r=7 behaves as 4 (target 255, final step clamps 248->255).
- Gamma (RGB_PWM_GAMMA_EN defined, RAMP_STEP=255): sel 1/2/3/4 -> duty 8/32/96/255 after one boundary each.
